// File: rtl/spPkg.sv
// ---------------------------------------------------------------------------
// spPkg -- shared signal-processing definitions.
//
// Provides the default vector length K, the component width W and the
// complex sample type cplx_t (signed I and Q, I in the upper half).
// CPLX_ZERO is the all-zero sample used for reset and idle values.
// ---------------------------------------------------------------------------
package spPkg;

    localparam int K = 4;
    localparam int W = 16;

    typedef struct packed {
        logic signed [W-1:0] i;
        logic signed [W-1:0] q;
    } cplx_t;

    localparam cplx_t CPLX_ZERO = '{i: {W{1'b0}}, q: {W{1'b0}}};

endpackage

// File: rtl/dbg_vec_slot.sv
// ---------------------------------------------------------------------------
// dbg_vec_slot -- one K-element complex vector register with an occupancy flag.
//
// Ports
//   clk   : clock, rising edge
//   rn    : asynchronous active-high reset (contents zeroed, slot empty)
//   load  : capture din and mark the slot full (wins over clear)
//   clear : mark the slot empty and zero the contents
//   din   : K elements to capture
//   dout  : stored K elements
//   full  : slot currently holds a vector
//
// The caller is responsible for qualifying load/clear with any global enable.
// ---------------------------------------------------------------------------
module dbg_vec_slot
    import spPkg::*;
#(
    parameter int K = spPkg::K
)
(
    input  logic  clk,
    input  logic  rn,
    input  logic  load,
    input  logic  clear,
    input  cplx_t din  [K],
    output cplx_t dout [K],
    output logic  full
);

    // Vector storage: load has priority so a move-in and free can share a cycle.
    always_ff @(posedge clk or posedge rn) begin
        if (rn) begin
            for (int k = 0; k < K; k++) begin
                dout[k] <= CPLX_ZERO;
            end
        end else if (load) begin
            for (int k = 0; k < K; k++) begin
                dout[k] <= din[k];
            end
        end else if (clear) begin
            for (int k = 0; k < K; k++) begin
                dout[k] <= CPLX_ZERO;
            end
        end
    end

    // Occupancy flag.
    always_ff @(posedge clk or posedge rn) begin
        if (rn) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/dbg_vec_serializer.sv
// ---------------------------------------------------------------------------
// dbg_vec_serializer -- turns K-element complex vectors into an element
// stream with a valid/ready handshake.
//
// Two vector slots are kept: ACTIVE (being sent) and PEND (queued). A third
// vector arriving while both are occupied is dropped and counted.
//
// Ports
//   clk      : clock, rising edge
//   rn       : asynchronous active-high reset
//   en       : global enable; when low all state holds
//   VecValid : single-cycle strobe, Vec is presented
//   Vec      : K input elements, index 0 sent first
//   SerValid : SerData/SerIdx/SerLast carry a valid element
//   SerReady : sink accepts the current element
//   SerData  : current element (I, Q)
//   SerIdx   : index of the current element in its vector
//   SerLast  : current element is index K-1
//   Overflow : sticky, a vector has been dropped
//   DropCnt  : number of dropped vectors, saturating
//
// All outputs are registered; the first element appears the cycle after the
// capturing edge and vectors follow each other without a bubble.
// ---------------------------------------------------------------------------
module dbg_vec_serializer
    import spPkg::*;
#(
    parameter int K = spPkg::K,
    parameter int W = spPkg::W
)
(
    input  logic                 clk,
    input  logic                 rn,
    input  logic                 en,
    input  logic                 VecValid,
    input  cplx_t                Vec [K],
    output logic                 SerValid,
    input  logic                 SerReady,
    output cplx_t                SerData,
    output logic [$clog2(K)-1:0] SerIdx,
    output logic                 SerLast,
    output logic                 Overflow,
    output logic [15:0]          DropCnt
);

    localparam int              IW        = $clog2(K);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(K - 1);
    localparam logic [IW-1:0]   IDX_ONE   = IW'(1);
    localparam logic [IW-1:0]   IDX_ZERO  = IW'(0);
    localparam logic [15:0]     DROP_MAX  = 16'hFFFF;
    localparam cplx_t           DATA_ZERO = '{i: {W{1'b0}}, q: {W{1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic          hs_s;
    logic          last_hs_s;
    logic          vv_s;

    logic          act_load_s;
    logic          act_clear_s;
    logic          act_sel_pend_s;
    logic          act_full_s;
    logic          pend_load_s;
    logic          pend_clear_s;
    logic          pend_full_s;
    logic          drop_s;

    cplx_t         act_din_s  [K];
    cplx_t         act_dout_s [K];
    cplx_t         pend_dout_s[K];
    cplx_t         act_src_s  [K];

    logic          valid_nxt_s;
    logic [IW-1:0] idx_nxt_s;
    logic          last_nxt_s;
    cplx_t         data_nxt_s;

    // Qualified events: nothing happens while en is low.
    assign hs_s      = SerValid & SerReady & en;
    assign last_hs_s = hs_s & (SerIdx == IDX_LAST);
    assign vv_s      = VecValid & en;

    // Slot control and next state.
    always_comb begin
        state_nxt_s    = state_r;
        act_load_s     = 1'b0;
        act_clear_s    = 1'b0;
        act_sel_pend_s = 1'b0;
        pend_load_s    = 1'b0;
        pend_clear_s   = 1'b0;
        drop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (vv_s) begin
                    act_load_s  = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (last_hs_s) begin
                    if (pend_full_s) begin
                        // PEND moves up first; a coincident vector refills PEND.
                        act_load_s     = 1'b1;
                        act_sel_pend_s = 1'b1;
                        pend_clear_s   = 1'b1;
                        pend_load_s    = vv_s;
                        state_nxt_s    = ST_SEND;
                    end else if (vv_s) begin
                        act_load_s  = 1'b1;
                        state_nxt_s = ST_SEND;
                    end else begin
                        act_clear_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else if (vv_s) begin
                    if (!act_full_s) begin
                        act_load_s = 1'b1;
                    end else if (!pend_full_s) begin
                        pend_load_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // ACTIVE input mux and the contents ACTIVE will hold after this edge.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            act_din_s[k] = DATA_ZERO;
            act_src_s[k] = DATA_ZERO;
        end
        for (int k = 0; k < K; k++) begin
            if (act_sel_pend_s) begin
                act_din_s[k] = pend_dout_s[k];
            end else begin
                act_din_s[k] = Vec[k];
            end
            if (act_load_s) begin
                act_src_s[k] = act_din_s[k];
            end else begin
                act_src_s[k] = act_dout_s[k];
            end
        end
    end

    // Next output element, looked up from the post-edge ACTIVE contents so
    // the outputs can be registered without adding latency.
    always_comb begin
        valid_nxt_s = (state_nxt_s == ST_SEND);
        idx_nxt_s   = SerIdx;
        last_nxt_s  = 1'b0;
        data_nxt_s  = DATA_ZERO;
        if (hs_s) begin
            if (SerIdx == IDX_LAST) begin
                idx_nxt_s = IDX_ZERO;
            end else begin
                idx_nxt_s = SerIdx + IDX_ONE;
            end
        end else begin
            idx_nxt_s = SerIdx;
        end
        if (valid_nxt_s) begin
            data_nxt_s = act_src_s[idx_nxt_s];
            last_nxt_s = (idx_nxt_s == IDX_LAST);
        end else begin
            idx_nxt_s  = IDX_ZERO;
            data_nxt_s = DATA_ZERO;
            last_nxt_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rn) begin
        if (rn) begin
            state_r <= ST_IDLE;
        end else if (en) begin
            state_r <= state_nxt_s;
        end
    end

    // Registered stream outputs.
    always_ff @(posedge clk or posedge rn) begin
        if (rn) begin
            SerValid <= 1'b0;
            SerIdx   <= IDX_ZERO;
            SerLast  <= 1'b0;
            SerData  <= DATA_ZERO;
        end else if (en) begin
            SerValid <= valid_nxt_s;
            SerIdx   <= idx_nxt_s;
            SerLast  <= last_nxt_s;
            SerData  <= data_nxt_s;
        end
    end

    // Drop bookkeeping: sticky flag plus saturating counter.
    always_ff @(posedge clk or posedge rn) begin
        if (rn) begin
            Overflow <= 1'b0;
            DropCnt  <= 16'h0000;
        end else if (drop_s) begin
            Overflow <= 1'b1;
            if (DropCnt != DROP_MAX) begin
                DropCnt <= DropCnt + 16'h0001;
            end
        end
    end

    dbg_vec_slot #(.K(K)) u_act (
        .clk   (clk),
        .rn    (rn),
        .load  (act_load_s),
        .clear (act_clear_s),
        .din   (act_din_s),
        .dout  (act_dout_s),
        .full  (act_full_s)
    );

    dbg_vec_slot #(.K(K)) u_pend (
        .clk   (clk),
        .rn    (rn),
        .load  (pend_load_s),
        .clear (pend_clear_s),
        .din   (Vec),
        .dout  (pend_dout_s),
        .full  (pend_full_s)
    );

endmodule

// File: tb/tb_dbg_vec_serializer.sv
// ---------------------------------------------------------------------------
// tb_dbg_vec_serializer -- directed, scoreboard-checked bench.
// Stimulus pushes the expected elements of every vector it expects to be
// accepted; the monitor pops and compares on each handshake.
// ---------------------------------------------------------------------------
module tb_dbg_vec_serializer;
    import spPkg::*;

    localparam int TK = spPkg::K;
    localparam int IW = $clog2(TK);

    logic          clk = 1'b0;
    logic          rn;
    logic          en;
    logic          VecValid;
    cplx_t         Vec [TK];
    logic          SerValid;
    logic          SerReady;
    cplx_t         SerData;
    logic [IW-1:0] SerIdx;
    logic          SerLast;
    logic          Overflow;
    logic [15:0]   DropCnt;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   exp_q[$];
    int            run_cnt = 0;
    int            last_run = 0;
    logic          stall_prev = 1'b0;

    always #5 clk = ~clk;

    dbg_vec_serializer dut (
        .clk      (clk),
        .rn       (rn),
        .en       (en),
        .VecValid (VecValid),
        .Vec      (Vec),
        .SerValid (SerValid),
        .SerReady (SerReady),
        .SerData  (SerData),
        .SerIdx   (SerIdx),
        .SerLast  (SerLast),
        .Overflow (Overflow),
        .DropCnt  (DropCnt)
    );

    function automatic cplx_t mk(input int v);
        cplx_t c;
        c.i = W'(v);
        c.q = W'(-v);
        return c;
    endfunction

    function automatic logic [63:0] pack_elem(input cplx_t d, input logic [IW-1:0] idx, input logic last);
        return 64'({d, idx, last});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element k of a vector with base b is (b+k+1, -(b+k+1)).
    task automatic send_vec(input int base, input bit accept);
        for (int k = 0; k < TK; k++) begin
            Vec[k] = mk(base + k + 1);
            if (accept) begin
                exp_q.push_back(pack_elem(mk(base + k + 1), IW'(k), (k == TK - 1)));
            end
        end
        VecValid = 1'b1;
        tick();
        VecValid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(SerValid), 64'd0);
        chk({tag, "_idx"},   64'(SerIdx),   64'd0);
        chk({tag, "_last"},  64'(SerLast),  64'd0);
        chk({tag, "_data"},  64'(SerData),  64'd0);
        chk({tag, "_ovf"},   64'(Overflow), 64'd0);
        chk({tag, "_drop"},  64'(DropCnt),  64'd0);
    endtask

    task automatic wait_idx2(input string tag);
        for (int t = 0; t < 10 && SerIdx != IW'(2); t++) begin
            tick();
        end
        chk(tag, 64'(SerIdx), 64'd2);
    endtask

    // Monitor: scoreboard compare on handshakes, valid-hold and run length.
    always @(negedge clk) begin
        if (rn) begin
            stall_prev = 1'b0;
            run_cnt    = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(SerValid), 64'd1);
            end
            if (en && SerValid && SerReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_elem: got 0x%0h, expected no element", pack_elem(SerData, SerIdx, SerLast));
                end else begin
                    chk("elem", pack_elem(SerData, SerIdx, SerLast), exp_q.pop_front());
                end
                run_cnt++;
            end else if (run_cnt != 0) begin
                last_run = run_cnt;
                run_cnt  = 0;
            end
            stall_prev = en && SerValid && !SerReady;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rn       = 1'b1;
        en       = 1'b1;
        VecValid = 1'b0;
        SerReady = 1'b1;
        for (int k = 0; k < TK; k++) Vec[k] = CPLX_ZERO;
        tick();
        tick();
        chk_reset_outputs("rst");
        rn = 1'b0;
        tick();

        // Single vector (1,-1)..(4,-4), latency one, four valid cycles.
        send_vec(0, 1'b1);
        chk("t1_latency_valid", 64'(SerValid), 64'd1);
        chk("t1_first_idx", 64'(SerIdx), 64'd0);
        chk("t1_first_data", 64'(SerData), 64'(mk(1)));
        repeat (6) tick();
        chk("t1_idle_after", 64'(SerValid), 64'd0);
        chk("t1_run", 64'(last_run), 64'd4);

        // VecValid with en low is neither captured nor dropped.
        en = 1'b0;
        send_vec(200, 1'b0);
        chk("en_low_valid", 64'(SerValid), 64'd0);
        en = 1'b1;
        repeat (2) tick();
        chk("en_low_valid_after", 64'(SerValid), 64'd0);
        chk("en_low_drop", 64'(DropCnt), 64'd0);

        // Back-to-back vectors, four cycles apart: 12 contiguous elements.
        send_vec(10, 1'b1);
        repeat (3) tick();
        send_vec(20, 1'b1);
        repeat (3) tick();
        send_vec(30, 1'b1);
        repeat (8) tick();
        chk("t2_run", 64'(last_run), 64'd12);
        chk("t2_ovf", 64'(Overflow), 64'd0);

        // Backpressure for five cycles at index 2.
        send_vec(40, 1'b1);
        wait_idx2("t3_reach_idx2");
        SerReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_frozen_idx", 64'(SerIdx), 64'd2);
            chk("t3_frozen_data", 64'(SerData), 64'(mk(43)));
        end
        SerReady = 1'b1;
        repeat (6) tick();
        chk("t3_idle_after", 64'(SerValid), 64'd0);

        // Overflow: two held, third dropped.
        SerReady = 1'b0;
        send_vec(50, 1'b1);
        send_vec(60, 1'b1);
        send_vec(70, 1'b0);
        chk("t4_ovf", 64'(Overflow), 64'd1);
        chk("t4_dropcnt", 64'(DropCnt), 64'd1);
        SerReady = 1'b1;
        repeat (10) tick();
        chk("t4_run", 64'(last_run), 64'd8);

        // VecValid on the last handshake with PEND full: no drop, no gap.
        send_vec(80, 1'b1);
        send_vec(90, 1'b1);
        repeat (2) tick();
        send_vec(100, 1'b1);
        repeat (10) tick();
        chk("t5_run", 64'(last_run), 64'd12);
        chk("t5_dropcnt", 64'(DropCnt), 64'd1);

        // Reset pulse mid-vector.
        send_vec(110, 1'b1);
        wait_idx2("t6_reach_idx2");
        rn = 1'b1;
        #1;
        chk_reset_outputs("t6_in_rst");
        exp_q.delete();
        tick();
        tick();
        rn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t6_quiet", 64'(SerValid), 64'd0);
        end
        send_vec(120, 1'b1);
        chk("t6_restart_valid", 64'(SerValid), 64'd1);
        chk("t6_restart_idx", 64'(SerIdx), 64'd0);
        chk("t6_restart_data", 64'(SerData), 64'(mk(121)));
        repeat (6) tick();
        chk("t6_run", 64'(last_run), 64'd4);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
